clk_reset_seq: RTL and testbench

- Downstream consumer of the system PLL's 48 MHz output and its locked flag.
- Sequences reset release in two steps: SDRAM controller first, then the Lynx core.
- Generates the free-running clock enables for the core: CPU phase enables and the pixel enable. Turbo selects the CPU divide ratio.
- Runs entirely in the 48 MHz domain.

---
 rtl/clk_reset_pkg.sv | 32 +++
 rtl/ce_divider.sv | 63 ++++++
 rtl/clk_reset_seq.sv | 154 +++++++++++++++
 tb/tb_clk_reset_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_reset_pkg.sv
// Shared types and default constants for the 48 MHz reset sequencer and clock-enable generation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_reset_pkg;

  // Sequencer states. The encoding is visible on the seq_state debug port.
  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    SDRAM_INIT = 2'd2,
    RUN        = 2'd3
  } seq_state_t;

  // Default timing at 48 MHz.
  localparam int LOCK_CYCLES_DEF   = 4800;  // 100 us lock-stable window
  localparam int SDRAM_TIMEOUT_DEF = 9600;  // 200 us maximum SDRAM init wait
  localparam int CPU_DIV_DEF       = 12;    // 4 MHz CPU
  localparam int CPU_DIV_TURBO_DEF = 6;     // 8 MHz CPU
  localparam int PIX_DIV_DEF       = 8;     // 6 MHz pixel

  // Returns the counter width for a counter whose largest value is max_val.
  // The extra bit keeps the terminal-count compare free of wrap-around.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  // Returns the larger of two integers. Used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running clock-enable divider: a counter 0..D-1 that pulses ce_p_o at 0 and ce_n_o at D/2.
// Latency: ce_p_o is high in the first cycle run_i is high; the counter clears on the edge run_i drops.
// Backpressure: none; enables run freely while run_i is high. A new ratio is taken only at wrap.
module ce_divider
  import clk_reset_pkg::*;
#(
  parameter  int MAX_DIV = CPU_DIV_DEF,
  localparam int DW      = cnt_width(MAX_DIV),
  localparam int CW      = cnt_width(MAX_DIV - 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] div_i,
  input  logic          run_i,
  input  logic          load_i,
  output logic          ce_p_o,
  output logic          ce_n_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] cnt_ext;
  logic          at_wrap;

  assign cnt_ext = DW'(cnt_q);
  assign at_wrap = (cnt_ext == (div_q - DW'(1)));

  // The ratio tracks div_i while idle, so the first period after release already uses it.
  // While running, the ratio changes only at wrap, so no period is ever cut short or stretched.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (!run_i) begin
      cnt_d = '0;
      div_d = div_i;
    end else if (at_wrap) begin
      cnt_d = '0;
      if (load_i) begin
        div_d = div_i;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and active-ratio registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      div_q <= DW'(MAX_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // Each enable is decoded from the counter and gated by run_i, so it drops in the same cycle run_i does.
  always_comb begin
    ce_p_o = run_i && (cnt_q == '0);
    ce_n_o = run_i && (cnt_ext == (div_q >> 1));
  end

endmodule

// File: rtl/clk_reset_seq.sv
// Reset sequencer and clock-enable generator for the Lynx core. Releases the SDRAM reset, then the core reset, once the PLL is stable.
// Latency: sdram_rst falls 2+LOCK_CYCLES+1 edges after locked is first sampled high; core_rst falls on SDRAM ready or after SDRAM_TIMEOUT cycles.
// Backpressure: none; loss of lock reasserts both resets and stops the enables. Async rst returns every output to its reset value at once.
module clk_reset_seq
  import clk_reset_pkg::*;
#(
  parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF,
  parameter int SDRAM_TIMEOUT = SDRAM_TIMEOUT_DEF,
  parameter int CPU_DIV       = CPU_DIV_DEF,
  parameter int CPU_DIV_TURBO = CPU_DIV_TURBO_DEF,
  parameter int PIX_DIV       = PIX_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       sdram_ready,
  input  logic       turbo,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n,
  output logic       ce_pix,
  output logic [1:0] seq_state
);

  // The sequencing counter is shared between the lock window and the SDRAM timeout.
  localparam int SEQ_MAX = max_int(LOCK_CYCLES, SDRAM_TIMEOUT - 1);
  localparam int SW      = cnt_width(SEQ_MAX);
  localparam int CPU_MAX = max_int(CPU_DIV, CPU_DIV_TURBO);
  localparam int CPU_DW  = cnt_width(CPU_MAX);
  localparam int PIX_DW  = cnt_width(PIX_DIV);

  logic              sync1_q;
  logic              lk_s_q;
  seq_state_t        state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              sdram_rst_q;
  logic              core_rst_q;
  logic              run;
  logic [CPU_DW-1:0] cpu_div;
  logic [PIX_DW-1:0] pix_div;
  logic              pix_ce_n_unused;

  // Two-flop synchroniser for the PLL lock flag, which is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= locked;
      lk_s_q  <= sync1_q;
    end
  end

  // Next-state and sequencing-counter logic. Losing lk_s always wins over every other exit.
  // STABILIZE holds until the counter reaches LOCK_CYCLES, so lk_s has been seen for LOCK_CYCLES
  // full cycles after the entry cycle before the SDRAM reset is released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s_q) begin
          state_d = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SW'(LOCK_CYCLES)) begin
          state_d = SDRAM_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      SDRAM_INIT: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (sdram_ready || (cnt_q == SW'(SDRAM_TIMEOUT - 1))) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and reset outputs. The resets are decoded from the next state, so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sdram_rst_q <= 1'b1;
      core_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdram_rst_q <= (state_d == WAIT_LOCK) || (state_d == STABILIZE);
      core_rst_q  <= (state_d != RUN);
    end
  end

  // Enables run only in RUN with lock still present. The dividers therefore clear on the same edge
  // the FSM drops back to WAIT_LOCK, and they start from phase 0 on every release.
  always_comb begin
    run     = (state_q == RUN) && lk_s_q;
    cpu_div = turbo ? CPU_DW'(CPU_DIV_TURBO) : CPU_DW'(CPU_DIV);
    pix_div = PIX_DW'(PIX_DIV);
  end

  ce_divider #(
    .MAX_DIV (CPU_MAX)
  ) u_cpu_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_i  (cpu_div),
    .run_i  (run),
    .load_i (1'b1),
    .ce_p_o (ce_cpu_p),
    .ce_n_o (ce_cpu_n)
  );

  ce_divider #(
    .MAX_DIV (PIX_DIV)
  ) u_pix_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_i  (pix_div),
    .run_i  (run),
    .load_i (1'b1),
    .ce_p_o (ce_pix),
    .ce_n_o (pix_ce_n_unused)
  );

  assign sdram_rst = sdram_rst_q;
  assign core_rst  = core_rst_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Testbench for clk_reset_seq: table-driven FSM phases plus hand-written release, turbo and async-reset sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_clk_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       sdram_ready;
  logic       turbo;
  logic       sdram_rst;
  logic       core_rst;
  logic       ce_cpu_p;
  logic       ce_cpu_n;
  logic       ce_pix;
  logic [1:0] seq_state;

  clk_reset_seq dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked),
    .sdram_ready (sdram_ready),
    .turbo       (turbo),
    .sdram_rst   (sdram_rst),
    .core_rst    (core_rst),
    .ce_cpu_p    (ce_cpu_p),
    .ce_cpu_n    (ce_cpu_n),
    .ce_pix      (ce_pix),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  // Edge index: after an edge settles, cyc holds the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] st;
    logic       srst;
    logic       crst;
    logic [2:0] ce;   // {ce_cpu_p, ce_cpu_n, ce_pix}
  } exp_t;

  typedef struct {
    logic       lk;
    logic       rdy;
    int         hold;  // rising edges to wait before sampling
    int         pat;   // 0 none, 1 normal enable pattern, 2 turbo-switch pattern
    logic [1:0] st;
    logic       srst;
    logic       crst;
    logic [2:0] ce;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, want, cyc);
  endtask

  task automatic push_exp(input logic [1:0] st, input logic srst, input logic crst, input logic [2:0] ce);
    exp_t e;
    e.st = st; e.srst = srst; e.crst = crst; e.ce = ce;
    sb.push_back(e);
  endtask

  task automatic compare_sb(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, " seq_state"}, int'(seq_state), int'(e.st));
    check({tag, " sdram_rst"}, int'(sdram_rst), int'(e.srst));
    check({tag, " core_rst"},  int'(core_rst),  int'(e.crst));
    check({tag, " ce{p,n,pix}"}, int'({ce_cpu_p, ce_cpu_n, ce_pix}), int'(e.ce));
  endtask

  // Expected enables t cycles after the first RUN cycle. In mode 2 turbo rises while the CPU counter is at 3,
  // so the first period stays 12 and the rest are 6 with the falling phase at offset 3.
  function automatic logic [2:0] exp_ce(input int mode, input int t);
    logic p, n;
    int   u;
    if (mode == 2 && t >= 12) begin
      u = t - 12;
      p = (u % 6 == 0);
      n = (u % 6 == 3);
    end else begin
      p = (t % 12 == 0);
      n = (t % 12 == 6);
    end
    return {p, n, (t % 8 == 0)};
  endfunction

  // Offset 0 (first RUN cycle) has already been checked by the caller.
  task automatic pattern(input int mode, input int n);
    int last_p  = 0;
    int min_gap = 1000;
    for (int t = 1; t <= n; t++) begin
      push_exp(2'd3, 1'b0, 1'b0, exp_ce(mode, t));
      @(posedge clk); #1;
      if (ce_cpu_p) begin
        if (t - last_p < min_gap) min_gap = t - last_p;
        last_p = t;
      end
      compare_sb($sformatf("%s t=%0d", (mode == 2) ? "turbo" : "run", t));
      if (mode == 2 && t == 3) turbo = 1'b1;
    end
    check("cpu_p_min_gap", min_gap, (mode == 2) ? 6 : 12);
  endtask

  task automatic wait_fall(input int which, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (((which == 0) ? sdram_rst : core_rst) == 1'b0) begin
        at_edge = cyc;
        break;
      end
    end
  endtask

  initial begin
    int e_s;
    int e_c;
    int e0;
    int found;

    //          lk    rdy   hold  pat st    srst  crst  ce
    vecs[0]  = '{1'b0, 1'b0, 3,    0, 2'd0, 1'b1, 1'b1, 3'b000}; // lock loss from RUN
    vecs[1]  = '{1'b1, 1'b0, 3,    0, 2'd1, 1'b1, 1'b1, 3'b000}; // relock -> STABILIZE
    vecs[2]  = '{1'b1, 1'b0, 2000, 0, 2'd1, 1'b1, 1'b1, 3'b000}; // count to ~2000
    vecs[3]  = '{1'b0, 1'b0, 3,    0, 2'd0, 1'b1, 1'b1, 3'b000}; // 3-cycle glitch
    vecs[4]  = '{1'b1, 1'b0, 3,    0, 2'd1, 1'b1, 1'b1, 3'b000}; // count restarts
    vecs[5]  = '{1'b1, 1'b0, 4800, 0, 2'd1, 1'b1, 1'b1, 3'b000}; // no early release
    vecs[6]  = '{1'b1, 1'b0, 1,    0, 2'd2, 1'b0, 1'b1, 3'b000}; // sdram_rst released
    vecs[7]  = '{1'b1, 1'b0, 49,   0, 2'd2, 1'b0, 1'b1, 3'b000}; // waiting for ready
    vecs[8]  = '{1'b1, 1'b1, 1,    1, 2'd3, 1'b0, 1'b0, 3'b101}; // ready at 50 -> RUN
    vecs[9]  = '{1'b0, 1'b1, 3,    0, 2'd0, 1'b1, 1'b1, 3'b000}; // lock loss in RUN
    vecs[10] = '{1'b1, 1'b1, 3,    0, 2'd1, 1'b1, 1'b1, 3'b000};
    vecs[11] = '{1'b1, 1'b1, 4800, 0, 2'd1, 1'b1, 1'b1, 3'b000};
    vecs[12] = '{1'b1, 1'b1, 1,    0, 2'd2, 1'b0, 1'b1, 3'b000};
    vecs[13] = '{1'b1, 1'b1, 1,    2, 2'd3, 1'b0, 1'b0, 3'b101}; // ready already high -> RUN, turbo pattern

    rst = 1'b1; locked = 1'b0; sdram_ready = 1'b0; turbo = 1'b0;
    repeat (3) @(posedge clk); #1;
    push_exp(2'd0, 1'b1, 1'b1, 3'b000);
    compare_sb("reset");

    // Lock present while rst is held must not advance anything.
    locked = 1'b1;
    repeat (3) @(posedge clk); #1;
    push_exp(2'd0, 1'b1, 1'b1, 3'b000);
    compare_sb("reset_held_locked");

    locked = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    while (cyc < 9) begin
      @(posedge clk); #1;
    end
    locked = 1'b1;                       // first sampled by edge 10

    wait_fall(0, e_s);
    check("sdram_rst_release_edge", e_s, 10 + 2 + 4800 + 1);
    push_exp(2'd2, 1'b0, 1'b1, 3'b000);
    compare_sb("sdram_init_entry");

    wait_fall(1, e_c);
    check("core_rst_timeout_edge", e_c, 10 + 2 + 4800 + 1 + 9600);
    push_exp(2'd3, 1'b0, 1'b0, 3'b101);
    compare_sb("run_entry");
    pattern(1, 40);

    for (int i = 0; i < 14; i++) begin
      locked      = vecs[i].lk;
      sdram_ready = vecs[i].rdy;
      push_exp(vecs[i].st, vecs[i].srst, vecs[i].crst, vecs[i].ce);
      repeat (vecs[i].hold) @(posedge clk);
      #1;
      compare_sb($sformatf("vec%0d", i));
      if (vecs[i].pat != 0) pattern(vecs[i].pat, 48);
    end

    // Async reset pulse between edges, taken right after a CPU rising-phase enable.
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ce_cpu_p) begin
        found = 1;
        break;
      end
    end
    check("ce_cpu_p_before_async_rst", found, 1);
    #2;
    rst = 1'b1;
    #1;
    push_exp(2'd0, 1'b1, 1'b1, 3'b000);
    compare_sb("async_rst_mid_cycle");
    rst = 1'b0;
    e0 = cyc + 1;                        // next edge samples locked=1 afresh
    wait_fall(0, e_s);
    check("restart_sdram_release_delay", e_s - e0, 2 + 4800 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
